da_timer_sequencer: RTL and testbench
=====================================

Name: da_timer_sequencer

Overview:
- Avalon-MM master that configures and sequences the system interval timer (16-bit data, 3-bit word address, registered readdata, no waitrequest) to pace DAC sample updates.
- On start it programs the period and starts the timer in continuous mode with interrupt enabled.
- On each timer IRQ it clears the timeout status and issues one sample_req/sample_ack handshake to the DAC datapath.
- It stops the timer after a programmed burst length or on a stop command.

Parameters:
- CNT_W, 16, width of burst_len and the sample counter.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- cfg_period  in  32  timer period value; timer fires every cfg_period+1 clocks
- cfg_burst_len  in  CNT_W  samples per run; 0 = run until stopped
- cfg_start  in  1  pulse: begin a run; ignored unless IDLE
- cfg_stop  in  1  pulse: end the run at the next safe point
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the run finishes and the FSM returns to IDLE
- avm_address  out  3  timer word address
- avm_chipselect  out  1  timer select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  16  timer write data
- avm_readdata  in  16  timer read data, valid one cycle after the address is presented
- timer_irq  in  1  timer interrupt, level, cleared by a write to address 0
- sample_req  out  1  request one DAC update; held until acknowledged
- sample_ack  in  1  DAC datapath accepted the sample
- sample_cnt  out  CNT_W  samples completed in the current run
- overrun  out  1  sticky flag: IRQ arrived while sample_req was still pending
- overrun_cnt  out  OVR_W  saturating count of overruns
- err  out  1  sticky flag: start verification failed (feature only; otherwise tied 0)

Behaviour:
- Reset values: busy=0, done=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, sample_req=0, sample_cnt=0, overrun=0, overrun_cnt=0, err=0.
- Master outputs are registered. Every access lasts exactly one cycle. Outside an access, chipselect=0 and write_n=1.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, REQ, STOP.
- IDLE:
  - cfg_start → latch cfg_period and cfg_burst_len.
  - Clear sample_cnt, overrun, overrun_cnt and err.
  - Go to WR_PL.
- WR_PL: write address 2 with period[15:0], then WR_PH.
- WR_PH: write address 3 with period[31:16], then WR_CTRL.
- WR_CTRL:
  - Write address 1 with 0x0007 (START | CONT | ITO), then RUN.
  - The period writes must precede the control write, because a period write stops the timer.
- RUN:
  - cfg_stop or stop_pend → STOP.
  - Otherwise, timer_irq=1 → CLR.
- CLR:
  - Write address 0 with 0x0000.
  - Go to REQ with sample_req=1 asserted in the following cycle.
  - timer_irq is not sampled for the cycle immediately after CLR, because the clear takes effect one cycle late.
- REQ:
  - Hold sample_req until sample_ack=1.
  - On sample_req && sample_ack: deassert sample_req next cycle and increment sample_cnt.
  - If burst_len≠0 and the new count equals burst_len → STOP.
  - Else if stop_pend → STOP.
  - Else → RUN.
- Overrun: in REQ, a timer_irq rising edge (after the CLR blanking cycle) sets overrun and increments overrun_cnt, saturating at all-ones. The sample is not queued; the next IRQ is handled normally.
- cfg_stop in WR_* or REQ sets stop_pend. A pending handshake always completes; stop never abandons an asserted sample_req.
- STOP:
  - Write address 1 with 0x0008 (STOP, ITO=0).
  - Then write address 0 with 0x0000 to clear any residual timeout.
  - Then IDLE with done=1 for one cycle; clear stop_pend.
- cfg_start outside IDLE: ignored.
- cfg_start and cfg_stop together in IDLE: start wins. stop_pend is set, so the run programs the timer then stops immediately with sample_cnt=0.
- sample_cnt wraps modulo 2^CNT_W when burst_len=0.
- Reset mid-run: all outputs return to reset values immediately. The timer is reset by the same reset_n.

Optional Feature:
- Macro: DA_TIMER_SEQ_VERIFY_EN.
- Defined:
  - Two states VERIFY and VERIFY_WAIT are inserted after WR_CTRL.
  - VERIFY: read address 0 (chipselect=1, write_n=1).
  - VERIFY_WAIT: sample avm_readdata one cycle later.
  - Bit1 (RUN)=1 → RUN.
  - Bit1=0 → set err, then STOP.
- Undefined: WR_CTRL goes directly to RUN, and err is tied 0.

Test Plan:
- Start with cfg_period=9, burst_len=3, ack immediately → bus writes (2,0x0009), (3,0x0000), (1,0x0007); three sample_req pulses 10 clocks apart; STOP writes (1,0x0008), (0,0x0000); done pulse; sample_cnt=3.
- burst_len=0, period=19; cfg_stop after 5 samples while RUN → STOP sequence within 1 cycle; sample_cnt=5; done=1.
- period=4, sample_ack delayed 12 cycles → overrun=1, overrun_cnt≥1, sample_req held until ack.
- cfg_stop while sample_req pending → handshake completes, sample_cnt increments, then STOP; no further requests.
- reset_n low mid-REQ → all outputs at reset values the same cycle; cfg_start afterwards restarts cleanly from WR_PL.
- With DA_TIMER_SEQ_VERIFY_EN, timer model returns readdata bit1=0 → err=1, STOP writes issued, done pulse, no sample_req.

Source files
------------

// File: rtl/da_timer_sequencer.sv
// Avalon-MM master that programs the interval timer and turns each timer IRQ into one DAC sample handshake.
// Define DA_TIMER_SEQ_VERIFY_EN to read back the timer RUN bit after starting it.
module da_timer_sequencer #(
  parameter int CNT_W = 16,
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      cfg_period,
  input  logic [CNT_W-1:0] cfg_burst_len,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  output logic             busy,
  output logic             done,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             timer_irq,
  output logic             sample_req,
  input  logic             sample_ack,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             overrun,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic             err
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, REQ, STOP, STOP_CLR
`ifdef DA_TIMER_SEQ_VERIFY_EN
    , VERIFY, VERIFY_WAIT
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      period_q;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             stop_pend;
  logic             irq_prev;
  logic             blank;
  logic             fire;
  logic             done_nxt;
  logic             err_set;
  logic             ovr_evt;
  logic             cs_nxt, wr_n_nxt;
  logic [2:0]       addr_nxt;
  logic [15:0]      wdata_nxt;
  logic             unused_sig;

  assign busy       = (state != IDLE);
  assign cnt_inc    = sample_cnt + CNT_W'(1);
  assign ovr_evt    = (state == REQ) && !blank && timer_irq && !irq_prev;
  assign unused_sig = ^{avm_readdata, err_set};

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    fire      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE:    if (cfg_start) state_nxt = WR_PL;
      WR_PL:   state_nxt = WR_PH;
      WR_PH:   state_nxt = WR_CTRL;
`ifdef DA_TIMER_SEQ_VERIFY_EN
      WR_CTRL: state_nxt = VERIFY;
      VERIFY:  state_nxt = VERIFY_WAIT;
      VERIFY_WAIT: begin
        if (avm_readdata[1]) begin
          state_nxt = RUN;
        end else begin
          err_set   = 1'b1;
          state_nxt = STOP;
        end
      end
`else
      WR_CTRL: state_nxt = RUN;
`endif
      RUN: begin
        if (cfg_stop || stop_pend) state_nxt = STOP;
        else if (timer_irq)        state_nxt = CLR;
      end
      CLR: state_nxt = REQ;
      REQ: begin
        if (sample_req && sample_ack) begin
          fire = 1'b1;
          if (burst_q != '0 && cnt_inc == burst_q) state_nxt = STOP;
          else if (stop_pend || cfg_stop)          state_nxt = STOP;
          else                                     state_nxt = RUN;
        end
      end
      STOP: state_nxt = STOP_CLR;
      STOP_CLR: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Bus outputs are decoded from the next state so the registered access lines up with that state.
    // WR_PL is only entered from IDLE, where period_q is not yet loaded, hence cfg_period.
    cs_nxt    = 1'b0;
    wr_n_nxt  = 1'b1;
    addr_nxt  = '0;
    wdata_nxt = '0;
    case (state_nxt)
      WR_PL: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0; addr_nxt = 3'd2; wdata_nxt = cfg_period[15:0];
      end
      WR_PH: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0; addr_nxt = 3'd3; wdata_nxt = period_q[31:16];
      end
      WR_CTRL: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0; addr_nxt = 3'd1; wdata_nxt = 16'h0007;
      end
      STOP: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0; addr_nxt = 3'd1; wdata_nxt = 16'h0008;
      end
      CLR, STOP_CLR: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0; addr_nxt = 3'd0; wdata_nxt = 16'h0000;
      end
`ifdef DA_TIMER_SEQ_VERIFY_EN
      VERIFY: begin
        cs_nxt = 1'b1; addr_nxt = 3'd0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      sample_req     <= 1'b0;
      done           <= 1'b0;
      period_q       <= '0;
      burst_q        <= '0;
      sample_cnt     <= '0;
      overrun        <= 1'b0;
      overrun_cnt    <= '0;
      stop_pend      <= 1'b0;
      irq_prev       <= 1'b0;
      blank          <= 1'b0;
    end else begin
      state          <= state_nxt;
      avm_chipselect <= cs_nxt;
      avm_write_n    <= wr_n_nxt;
      avm_address    <= addr_nxt;
      avm_writedata  <= wdata_nxt;
      sample_req     <= (state_nxt == REQ);
      done           <= done_nxt;
      irq_prev       <= timer_irq;
      blank          <= (state == CLR);
      if (state == IDLE && cfg_start) begin
        period_q    <= cfg_period;
        burst_q     <= cfg_burst_len;
        sample_cnt  <= '0;
        overrun     <= 1'b0;
        overrun_cnt <= '0;
        stop_pend   <= cfg_stop;
      end else begin
        if (done_nxt)                        stop_pend <= 1'b0;
        else if (cfg_stop && state != IDLE)  stop_pend <= 1'b1;
        if (fire) sample_cnt <= cnt_inc;
        if (ovr_evt) begin
          overrun <= 1'b1;
          if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
      end
    end
  end

`ifdef DA_TIMER_SEQ_VERIFY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        err <= 1'b0;
    else if (state == IDLE && cfg_start) err <= 1'b0;
    else if (err_set)                    err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_da_timer_sequencer.sv
// Self-checking bench for da_timer_sequencer: behavioural interval-timer model, DAC ack responder,
// transaction-level expectations (bus write list, sample count, request spacing) from the run parameters.
module tb_da_timer_sequencer;
  localparam int CNT_W = 16;
  localparam int OVR_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [31:0]      cfg_period = '0;
  logic [CNT_W-1:0] cfg_burst_len = '0;
  logic             cfg_start = 1'b0;
  logic             cfg_stop = 1'b0;
  logic             busy, done;
  logic [2:0]       avm_address;
  logic             avm_chipselect, avm_write_n;
  logic [15:0]      avm_writedata;
  logic [15:0]      avm_readdata;
  logic             timer_irq;
  logic             sample_req;
  logic             sample_ack = 1'b0;
  logic [CNT_W-1:0] sample_cnt;
  logic             overrun;
  logic [OVR_W-1:0] overrun_cnt;
  logic             err;

  always #5 clk = ~clk;

  da_timer_sequencer #(.CNT_W(CNT_W), .OVR_W(OVR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_period(cfg_period), .cfg_burst_len(cfg_burst_len),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .timer_irq(timer_irq),
    .sample_req(sample_req), .sample_ack(sample_ack),
    .sample_cnt(sample_cnt), .overrun(overrun), .overrun_cnt(overrun_cnt),
    .err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Interval timer: fires every period+1 clocks; IRQ is registered so a clear is seen one cycle late.
  logic [31:0] t_period, t_cnt;
  logic        t_run, t_to, t_ito, t_cont;
  bit          force_not_run = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_period <= '0; t_cnt <= '0; t_run <= 1'b0; t_to <= 1'b0;
      t_ito <= 1'b0; t_cont <= 1'b0; timer_irq <= 1'b0; avm_readdata <= '0;
    end else begin
      timer_irq <= t_to & t_ito;
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to  <= 1'b1;
          t_cnt <= t_period;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito  <= avm_writedata[0];
            t_cont <= avm_writedata[1];
            if (avm_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
            if (avm_writedata[3]) t_run <= 1'b0;
          end
          3'd2: begin t_period[15:0]  <= avm_writedata; t_run <= 1'b0; end
          3'd3: begin t_period[31:16] <= avm_writedata; t_run <= 1'b0; end
          default: ;
        endcase
      end
      if (avm_chipselect && avm_write_n)
        avm_readdata <= (avm_address == 3'd0) ? {14'b0, t_run & ~force_not_run, t_to} : 16'h0;
    end
  end

  // Bus/handshake monitor and DAC ack responder share one process to keep their ordering fixed.
  int          cyc = 0;
  logic [18:0] wlog[$];
  int          req_t[$];
  int          done_cnt = 0;
  int          ack_delay = 0;
  int          ack_wait = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (avm_chipselect && !avm_write_n) wlog.push_back({avm_address, avm_writedata});
    if (sample_req && !prev_req) req_t.push_back(cyc);
    if (done) done_cnt++;
    if (reset_n && prev_req && !prev_ack) check("req_held", sample_req, 1'b1);
    prev_req = sample_req;
    if (sample_req && !sample_ack) begin
      if (ack_wait >= ack_delay) sample_ack = 1'b1;
      else ack_wait++;
    end else begin
      sample_ack = 1'b0;
      ack_wait   = 0;
    end
    prev_ack = sample_ack;
  end

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_cs"},    avm_chipselect, 1'b0);
    check({tag, "_wr_n"},  avm_write_n, 1'b1);
    check({tag, "_addr"},  avm_address, 3'd0);
    check({tag, "_wdata"}, avm_writedata, 16'h0);
    check({tag, "_req"},   sample_req, 1'b0);
    check({tag, "_cnt"},   sample_cnt, '0);
    check({tag, "_ovr"},   overrun, 1'b0);
    check({tag, "_ovrc"},  overrun_cnt, '0);
    check({tag, "_err"},   err, 1'b0);
  endtask

  task automatic do_run(input logic [31:0] p, input logic [CNT_W-1:0] b, input int d, input bit with_stop);
    wlog.delete();
    req_t.delete();
    done_cnt      = 0;
    ack_delay     = d;
    cfg_period    = p;
    cfg_burst_len = b;
    cfg_start     = 1'b1;
    cfg_stop      = with_stop;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    check("busy_run", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done_cnt != 0, 1'b1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic wait_cnt(input int target, input int budget);
    int k = 0;
    while (sample_cnt != target[CNT_W-1:0] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("cnt_reached", sample_cnt, target);
  endtask

  task automatic wait_req(input int budget);
    int k = 0;
    while (!sample_req && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("req_seen", sample_req, 1'b1);
  endtask

  // Expected write list: program period low/high, start, one IRQ clear per sample, stop, final clear.
  task automatic check_writes(input logic [31:0] p, input int nsamp);
    logic [18:0] exp[$];
    int n;
    exp.push_back({3'd2, p[15:0]});
    exp.push_back({3'd3, p[31:16]});
    exp.push_back({3'd1, 16'h0007});
    for (int i = 0; i < nsamp; i++) exp.push_back({3'd0, 16'h0000});
    exp.push_back({3'd1, 16'h0008});
    exp.push_back({3'd0, 16'h0000});
    check("n_writes", wlog.size(), exp.size());
    n = (wlog.size() < exp.size()) ? wlog.size() : exp.size();
    for (int i = 0; i < n; i++) check($sformatf("wr%0d", i), wlog[i], exp[i]);
  endtask

  task automatic check_gaps(input logic [31:0] p);
    for (int i = 1; i < req_t.size(); i++) check("req_gap", req_t[i] - req_t[i-1], p + 1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]      p;
    logic [CNT_W-1:0] b;
    int               d;

    repeat (3) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic burst of three with immediate ack
    do_run(32'd9, 16'd3, 0, 1'b0);
    wait_done(200);
    check("cnt_t1", sample_cnt, 3);
    check("nreq_t1", req_t.size(), 3);
    check_writes(32'd9, 3);
    check_gaps(32'd9);
    check("ovr_t1", overrun, 1'b0);
    check("err_t1", err, 1'b0);

    // Free-running, stopped from RUN after five samples
    do_run(32'd19, 16'd0, 0, 1'b0);
    wait_cnt(5, 400);
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    check("stop_lat", {avm_chipselect, avm_write_n, avm_address, avm_writedata},
          {1'b1, 1'b0, 3'd1, 16'h0008});
    wait_done(20);
    check("cnt_t2", sample_cnt, 5);
    check_writes(32'd19, 5);

    // Slow ack against a short period
    do_run(32'd4, 16'd2, 12, 1'b0);
    wait_done(300);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_cnt_min", overrun_cnt >= 1, 1'b1);
    check("cnt_t3", sample_cnt, 2);
    check_writes(32'd4, 2);

    // Stop while a request is pending
    do_run(32'd10, 16'd0, 6, 1'b0);
    wait_req(100);
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    wait_done(100);
    check("cnt_t4", sample_cnt, 1);
    check_writes(32'd10, 1);
    repeat (30) @(negedge clk);
    check("no_req_after", req_t.size(), 1);

    // Start and stop together
    do_run(32'd15, 16'd4, 0, 1'b1);
    wait_done(50);
    check("cnt_ss", sample_cnt, 0);
    check_writes(32'd15, 0);
    check("no_req_ss", req_t.size(), 0);

    // Reset in the middle of a request, then a clean restart
    do_run(32'd10, 16'd0, 20, 1'b0);
    wait_req(100);
    #2 reset_n = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    do_run(32'd12, 16'd2, 1, 1'b0);
    wait_done(200);
    check("cnt_t6", sample_cnt, 2);
    check_writes(32'd12, 2);
    check_gaps(32'd12);

`ifdef DA_TIMER_SEQ_VERIFY_EN
    // Timer refuses to report RUN after the start write
    force_not_run = 1'b1;
    do_run(32'd10, 16'd3, 0, 1'b0);
    wait_done(50);
    force_not_run = 1'b0;
    check("err_vfy", err, 1'b1);
    check("cnt_vfy", sample_cnt, 0);
    check_writes(32'd10, 0);
    check("no_req_vfy", req_t.size(), 0);
`endif

    // Randomised runs
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(30, 8);
      b = CNT_W'($urandom_range(5, 1));
      d = $urandom_range(3, 0);
      do_run(p, b, d, 1'b0);
      wait_done((int'(b) + 2) * (int'(p) + 1) + 50);
      check("cnt_rnd", sample_cnt, b);
      check("nreq_rnd", req_t.size(), b);
      check_writes(p, int'(b));
      check_gaps(p);
      check("ovr_rnd", overrun, 1'b0);
      check("err_rnd", err, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
